// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int ROW_IW = $clog2(ROWS);
   localparam int COL_IW = $clog2(COLS);
   localparam logic [ROWS-1:0] ROW_RST = 4'b1110;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

   typedef struct packed {
      logic              single;
      logic [COL_IW-1:0] idx;
   } low_idx_t;

   // Index of the low column plus a flag that exactly one column is low.
   function automatic low_idx_t onehot_low_idx(input logic [COLS-1:0] v);
      low_idx_t r;
      int       n;
      r = '0;
      n = 0;
      for (int i = 0; i < COLS; i++) begin
         if (!v[i]) begin
            n++;
            r.idx = COL_IW'(i);
         end
      end
      r.single = (n == 1);
      return r;
   endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module keypad_sync2 #(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad controller: row sweep, column sampling, press/release debounce and a
// single-entry valid/ready key output with drop indication.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       key_drop
);

   localparam int DIV_W = $clog2(SCAN_DIV) + 1;
   localparam int DEB_W = $clog2(DEBOUNCE_CYC) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_TERM = DEB_W'(DEBOUNCE_CYC);

   logic [COLS-1:0]   col_s;
   kp_state_t         state_q;
   logic [DIV_W-1:0]  div_q;
   logic [DEB_W-1:0]  deb_q;
   logic [DEB_W-1:0]  deb_d;
   logic [ROWS-1:0]   row_q;
   logic [ROW_IW-1:0] row_idx_q;
   logic [COL_IW-1:0] col_idx_q;
   logic [COLS-1:0]   pat_q;
   logic [3:0]        key_code_q;
   logic              key_valid_q;
   logic              key_drop_q;
   low_idx_t          sel;
   logic              load_d;

   keypad_sync2 #(.W(COLS), .RST_VAL(4'hF)) u_sync (
      .clk     (clk),
      .rst_n_i (rst),
      .d_i     (col),
      .q_o     (col_s)
   );

   // Debounce counter saturates at the terminal count instead of wrapping.
   always_comb begin
      deb_d  = (deb_q == DEB_TERM) ? deb_q : deb_q + 1'b1;
      sel    = onehot_low_idx(col_s);
      load_d = (state_q == DEBOUNCE) && (col_s == pat_q) && (deb_d == DEB_TERM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SCAN;
         div_q       <= '0;
         deb_q       <= '0;
         row_q       <= ROW_RST;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
         pat_q       <= '1;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_drop_q  <= 1'b0;
      end else begin
         key_drop_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (sel.single) begin
                     state_q   <= DEBOUNCE;
                     pat_q     <= col_s;
                     col_idx_q <= sel.idx;
                     deb_q     <= '0;
                  end else begin
                     row_q     <= {row_q[ROWS-2:0], row_q[ROWS-1]};
                     row_idx_q <= row_idx_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (col_s != pat_q) begin
                  deb_q     <= '0;
                  state_q   <= SCAN;
                  row_q     <= {row_q[ROWS-2:0], row_q[ROWS-1]};
                  row_idx_q <= row_idx_q + 1'b1;
               end else if (deb_d == DEB_TERM) begin
                  deb_q   <= '0;
                  state_q <= HELD;
               end else begin
                  deb_q <= deb_d;
               end
            end
            HELD: begin
               if (col_s != '1) begin
                  deb_q <= '0;
               end else if (deb_d == DEB_TERM) begin
                  deb_q     <= '0;
                  state_q   <= SCAN;
                  row_q     <= {row_q[ROWS-2:0], row_q[ROWS-1]};
                  row_idx_q <= row_idx_q + 1'b1;
               end else begin
                  deb_q <= deb_d;
               end
            end
            default: state_q <= SCAN;
         endcase

         // A same-cycle consume frees the slot, so the new code is accepted then.
         if (load_d) begin
            if (!key_valid_q || key_ready) begin
               key_code_q  <= {row_idx_q, col_idx_q};
               key_valid_q <= 1'b1;
            end else begin
               key_drop_q <= 1'b1;
            end
         end else if (key_valid_q && key_ready) begin
            key_valid_q <= 1'b0;
         end
      end
   end

   assign row       = row_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_drop  = key_drop_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, directed presses, key scoreboard.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] col;
   logic [3:0] row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_drop;

   logic [3:0] keys [4];
   int         exp_q [$];
   int         n_total = 0;
   int         n_pass  = 0;
   int         vld_cycles = 0;
   int         drop_cnt   = 0;

   keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_drop  (key_drop)
   );

   always #5 clk = ~clk;

   // Pressed key in a driven (low) row pulls its column low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++)
         if (!row[r]) col = col & ~keys[r];
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_row(input logic [3:0] r, input int bound);
      int n;
      n = 0;
      while (row != r && n < bound) begin
         step(1);
         n++;
      end
      check("wait_row", int'(row), int'(r));
   endtask

   task automatic wait_valid(input string name, input int bound);
      int n;
      n = 0;
      while (!key_valid && n < bound) begin
         step(1);
         n++;
      end
      check(name, int'(key_valid), 1);
   endtask

   // Monitor: every accepted key must match the oldest expected code.
   always @(negedge clk) begin
      if (rst) begin
         if (key_valid) vld_cycles++;
         if (key_drop)  drop_cnt++;
         if (key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
               check("key_expected", 0, 1);
            end else begin
               check("key_code", int'(key_code), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] seq [4];
      int         v0;
      int         d0;
      int         n;
      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int r = 0; r < 4; r++) keys[r] = 4'h0;
      rst       = 1'b0;
      key_ready = 1'b1;

      // Reset state and free-running sweep
      step(2);
      check("rst_row", int'(row), 4'b1110);
      check("rst_valid", int'(key_valid), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_drop", int'(key_drop), 0);
      rst = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step(1);
         check("sweep_row", int'(row), int'(seq[(k / 4) % 4]));
      end

      // Clean press: row 2, column 1 -> code 9
      keys[2] = 4'b0010;
      exp_q.push_back(9);
      v0 = vld_cycles;
      wait_row(4'b1011, 20);
      n = 0;
      while (!key_valid && n < 40) begin
         step(1);
         n++;
      end
      check("press_latency", n, 12);
      step(28);
      keys[2] = 4'h0;
      step(30);
      check("valid_cycles", vld_cycles - v0, 1);
      check("press_queue", exp_q.size(), 0);

      // Bounce during debounce
      v0 = vld_cycles;
      wait_row(4'b0111, 40);
      keys[2] = 4'b0010;
      wait_row(4'b1011, 20);
      step(5);
      check("bounce_frozen", int'(row), 4'b1011);
      keys[2] = 4'h0;
      n = 0;
      while (row == 4'b1011 && n < 20) begin
         step(1);
         n++;
      end
      check("bounce_exit_cycles", n, 3);
      check("bounce_next_row", int'(row), 4'b0111);

      // Two columns low in one row is ignored
      keys[0] = 4'b0110;
      wait_row(4'b1110, 20);
      step(4);
      check("multi_row1", int'(row), 4'b1101);
      step(4);
      check("multi_row2", int'(row), 4'b1011);
      keys[0] = 4'h0;
      step(20);
      check("no_valid_bounce_multi", vld_cycles - v0, 0);

      // Backpressure: second key dropped, first held
      key_ready = 1'b0;
      d0 = drop_cnt;
      keys[1] = 4'b0010;
      exp_q.push_back(5);
      wait_valid("bp_first_valid", 60);
      keys[1] = 4'h0;
      step(20);
      check("bp_valid_hold", int'(key_valid), 1);
      keys[1] = 4'b1000;
      n = 0;
      while (!key_drop && n < 60) begin
         step(1);
         n++;
      end
      check("bp_drop_seen", int'(key_drop), 1);
      check("bp_code_kept", int'(key_code), 5);
      check("bp_valid_kept", int'(key_valid), 1);
      keys[1] = 4'h0;
      step(20);
      check("bp_drop_count", drop_cnt - d0, 1);
      key_ready = 1'b1;
      step(1);
      check("bp_valid_clear", int'(key_valid), 0);
      check("bp_code_retain", int'(key_code), 5);

      // Asynchronous reset while debouncing
      keys[3] = 4'b0001;
      wait_row(4'b1011, 30);
      n = 0;
      while (row == 4'b1011 && n < 20) begin
         step(1);
         n++;
      end
      step(6);
      check("deb_frozen", int'(row), 4'b0111);
      #2;
      rst = 1'b0;
      #1;
      check("arst_deb_row", int'(row), 4'b1110);
      check("arst_deb_valid", int'(key_valid), 0);
      check("arst_deb_code", int'(key_code), 0);
      check("arst_deb_drop", int'(key_drop), 0);
      keys[3] = 4'h0;
      step(1);

      // Asynchronous reset with a pending key
      key_ready = 1'b0;
      rst = 1'b1;
      keys[0] = 4'b0100;
      wait_valid("pend_valid", 60);
      check("pend_code", int'(key_code), 2);
      #2;
      rst = 1'b0;
      #1;
      check("arst_pend_valid", int'(key_valid), 0);
      check("arst_pend_code", int'(key_code), 0);
      keys[0] = 4'h0;
      step(1);
      rst = 1'b1;
      step(1);
      check("restart_row0", int'(row), 4'b1110);
      step(3);
      check("restart_row1", int'(row), 4'b1101);

      key_ready = 1'b1;
      step(5);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
